// File: rtl/mc_main_ctrl_if.sv
// Controller <-> IR/ALU/datapath bundle: IR fields and ALU flags in, ALU op, enables and debug state out.
interface mc_main_ctrl_if #(
    parameter int ALUCTR_W = 4,
    parameter int STATE_W  = 4
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          rt;
    logic                ifzero;
    logic                ifgtz;
    logic                ifeqz;
    logic [ALUCTR_W-1:0] aluctr;
    logic                alusrc_b;
    logic [1:0]          extop;
    logic [1:0]          regdst;
    logic [1:0]          memtoreg;
    logic [1:0]          pcsrc;
    logic                pcwrite;
    logic                irwrite;
    logic                regwrite;
    logic                memwrite;
    logic                instr_done;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, funct, rt, ifzero, ifgtz, ifeqz,
        output aluctr, alusrc_b, extop, regdst, memtoreg, pcsrc,
               pcwrite, irwrite, regwrite, memwrite, instr_done, state
    );

    modport slave (
        output opcode, funct, rt, ifzero, ifgtz, ifeqz,
        input  aluctr, alusrc_b, extop, regdst, memtoreg, pcsrc,
               pcwrite, irwrite, regwrite, memwrite, instr_done, state
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller driving ALU op and datapath enables.
// Latency 2-5 cycles per instruction; outputs combinational from state + IR fields; no backpressure.
// Define REGIMM_BRANCH_EN to decode REGIMM bgez/bltz as branches.
module mc_main_ctrl #(
    parameter int ALUCTR_W = 4,
    parameter int STATE_W  = 4
) (
    input  logic           clk,
    input  logic           reset,
    mc_main_ctrl_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  EXE_R  = 4'd2,  EXE_I  = 4'd3,
        MEM_AD = 4'd4,  MEM_RD = 4'd5,  MEM_WR = 4'd6,  WB_ALU = 4'd7,
        WB_MEM = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10
    } state_t;

    localparam logic [ALUCTR_W-1:0] ALU_ADDU = ALUCTR_W'(0);
    localparam logic [ALUCTR_W-1:0] ALU_SUBU = ALUCTR_W'(1);
    localparam logic [ALUCTR_W-1:0] ALU_ORI  = ALUCTR_W'(2);
    localparam logic [ALUCTR_W-1:0] ALU_SRLV = ALUCTR_W'(3);

    localparam logic [5:0] OP_R    = 6'b000000, OP_ORI = 6'b001101, OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011, OP_SW  = 6'b101011, OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101, OP_BGTZ = 6'b000111, OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] F_ADDU  = 6'b100001, F_SUBU = 6'b100011, F_SRLV = 6'b000110;
    localparam logic [5:0] F_JR    = 6'b001000;

    state_t state_q, state_d;

    logic [ALUCTR_W-1:0] aluctr;
    logic                alusrc_b, pcwrite, irwrite, regwrite, memwrite, instr_done;
    logic [1:0]          extop, regdst, memtoreg, pcsrc;
    logic                is_r_alu, is_jr, is_jump, is_branch, regimm_br, taken;

`ifdef REGIMM_BRANCH_EN
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [4:0] RT_BGEZ   = 5'b00001, RT_BLTZ = 5'b00000;
    assign regimm_br = (bus.opcode == OP_REGIMM) && (bus.rt == RT_BGEZ || bus.rt == RT_BLTZ);
`else
    logic unused_regimm;
    assign regimm_br     = 1'b0;
    assign unused_regimm = ^{bus.rt, bus.ifeqz};
`endif

    assign is_r_alu  = (bus.opcode == OP_R) &&
                       (bus.funct == F_ADDU || bus.funct == F_SUBU || bus.funct == F_SRLV);
    assign is_jr     = (bus.opcode == OP_R) && (bus.funct == F_JR);
    assign is_jump   = is_jr || bus.opcode == OP_J || bus.opcode == OP_JAL;
    assign is_branch = bus.opcode == OP_BEQ || bus.opcode == OP_BNE ||
                       bus.opcode == OP_BGTZ || bus.opcode == OP_BLEZ || regimm_br;

    // Only meaningful in BRANCH; every other state ignores the flags.
    always_comb begin
        taken = 1'b0;
        case (bus.opcode)
            OP_BEQ:    taken = bus.ifzero;
            OP_BNE:    taken = !bus.ifzero;
            OP_BGTZ:   taken = bus.ifgtz;
            OP_BLEZ:   taken = !bus.ifgtz;
`ifdef REGIMM_BRANCH_EN
            OP_REGIMM: taken = (bus.rt == RT_BGEZ) ? (bus.ifgtz | bus.ifeqz) : !(bus.ifgtz | bus.ifeqz);
`endif
            default:   taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        aluctr     = ALU_ADDU;
        alusrc_b   = 1'b0;
        extop      = 2'd0;
        regdst     = 2'd0;
        memtoreg   = 2'd0;
        pcsrc      = 2'd0;
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                if (is_r_alu)                                        state_d = EXE_R;
                else if (is_jump)                                    state_d = JUMP;
                else if (bus.opcode == OP_ORI || bus.opcode == OP_LUI) state_d = EXE_I;
                else if (bus.opcode == OP_LW || bus.opcode == OP_SW)   state_d = MEM_AD;
                else if (is_branch)                                  state_d = BRANCH;
                else begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXE_R: begin
                aluctr  = (bus.funct == F_SUBU) ? ALU_SUBU :
                          (bus.funct == F_SRLV) ? ALU_SRLV : ALU_ADDU;
                state_d = WB_ALU;
            end
            EXE_I: begin
                aluctr   = ALU_ORI;
                alusrc_b = 1'b1;
                extop    = (bus.opcode == OP_LUI) ? 2'd2 : 2'd0;
                state_d  = WB_ALU;
            end
            WB_ALU: begin
                regwrite   = 1'b1;
                regdst     = (bus.opcode == OP_R) ? 2'd1 : 2'd0;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_AD: begin
                alusrc_b = 1'b1;
                extop    = 2'd1;
                state_d  = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: state_d = WB_MEM;
            MEM_WR: begin
                memwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            WB_MEM: begin
                regwrite   = 1'b1;
                memtoreg   = 2'd1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                aluctr     = ALU_SUBU;
                pcsrc      = 2'd1;
                pcwrite    = taken;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
                if (bus.opcode == OP_R) begin
                    pcsrc = 2'd3;
                end else begin
                    pcsrc = 2'd2;
                    if (bus.opcode == OP_JAL) begin
                        regwrite = 1'b1;
                        regdst   = 2'd2;
                        memtoreg = 2'd2;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
        // Gate everything while reset is high so no partial write escapes mid-instruction.
        if (reset) begin
            aluctr     = ALU_ADDU;
            alusrc_b   = 1'b0;
            extop      = 2'd0;
            regdst     = 2'd0;
            memtoreg   = 2'd0;
            pcsrc      = 2'd0;
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign bus.aluctr     = aluctr;
    assign bus.alusrc_b   = alusrc_b;
    assign bus.extop      = extop;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.pcsrc      = pcsrc;
    assign bus.pcwrite    = pcwrite;
    assign bus.irwrite    = irwrite;
    assign bus.regwrite   = regwrite;
    assign bus.memwrite   = memwrite;
    assign bus.instr_done = instr_done;
    assign bus.state      = reset ? FETCH : state_q;
endmodule
